aes_inv_key_schedule: RTL and testbench

- Generates AES-128 decryption round keys in reverse order: round 10 key first, down to round 0, which is the cipher key.
- Given a cipher key, it first runs the forward key expansion internally for 10 cycles. It then serves one round key per consumer request by inverting the key-schedule recurrence, so no 11-entry key RAM is needed.
- Sits between the key-load interface and the inverse-cipher datapath, which takes keys in round order 10..0.

---
 rtl/aes_pkg.sv | 45 ++++
 rtl/aes_inv_key_schedule_if.sv | 22 ++
 rtl/aes_sub_word.sv | 16 +
 rtl/aes_inv_key_schedule.sv | 114 +++++++++++
 tb/tb_aes_inv_key_schedule.sv | 365 ++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/aes_pkg.sv
// Shared AES constants: controller state encoding, round count, Rcon and the forward S-box.
package aes_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_EXPAND = 2'd1,
        ST_SERVE  = 2'd2
    } state_t;

    localparam logic [3:0] ROUNDS = 4'd10;

    // Index 0 and 11..15 are never used by the key schedule; they read as zero.
    localparam logic [7:0] RCON_TAB [16] = '{
        8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40,
        8'h80, 8'h1b, 8'h36, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00
    };

    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    function automatic logic [31:0] rcon(input logic [3:0] idx);
        return {RCON_TAB[idx], 24'h000000};
    endfunction

    function automatic logic [31:0] rot_word(input logic [31:0] w);
        return {w[23:0], w[31:24]};
    endfunction

endpackage

// File: rtl/aes_inv_key_schedule_if.sv
// Key-load and round-key bus of the inverse key schedule.
// key_valid is the producer's valid and next the consumer's ready: a round key
// transfers on a clock where both are high; key_out/key_round hold otherwise.
interface aes_inv_key_schedule_if;
    logic         start;
    logic [127:0] key_in;
    logic         next;
    logic [127:0] key_out;
    logic [3:0]   key_round;
    logic         key_valid;
    logic         busy;

    modport master (
        output start, key_in, next,
        input  key_out, key_round, key_valid, busy
    );

    modport slave (
        input  start, key_in, next,
        output key_out, key_round, key_valid, busy
    );
endinterface

// File: rtl/aes_sub_word.sv
// Combinational forward S-box applied to each byte of a 32-bit word.
module aes_sub_word
    import aes_pkg::*;
(
    input  logic [31:0] word_in,
    output logic [31:0] word_out
);

    always_comb begin
        word_out = '0;
        for (int i = 0; i < 4; i++) begin
            word_out[8*i +: 8] = SBOX[word_in[8*i +: 8]];
        end
    end

endmodule

// File: rtl/aes_inv_key_schedule.sv
// AES-128 decryption key source: expands the cipher key forward to round 10,
// then walks the recurrence backwards one round per accepted request.
module aes_inv_key_schedule
    import aes_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset_n,
    aes_inv_key_schedule_if.slave bus,
    output state_t                dbg_state
);

    state_t       state_q, state_d;
    logic [3:0]   cnt_q, cnt_d;
    logic [127:0] key_q, key_d;
    logic [3:0]   round_q, round_d;
    logic         valid_q, valid_d;
    logic         busy_q, busy_d;

    logic [31:0] w0, w1, w2, w3;
    logic [31:0] v0, v1, v2, v3;
    logic [31:0] f0, f1, f2, f3;
    logic [31:0] sub_in, sub_out, t_word;

    // One S-box word serves both directions: W3 when expanding, W3^W2 when serving.
    assign sub_in = rot_word((state_q == ST_SERVE) ? (key_q[31:0] ^ key_q[63:32])
                                                   : key_q[31:0]);

    aes_sub_word u_sub_word (
        .word_in  (sub_in),
        .word_out (sub_out)
    );

    always_comb begin
        {w0, w1, w2, w3} = key_q;
        t_word = sub_out ^ rcon((state_q == ST_SERVE) ? round_q : cnt_q);
        f0 = w0 ^ t_word;
        f1 = w1 ^ f0;
        f2 = w2 ^ f1;
        f3 = w3 ^ f2;
        v3 = w3 ^ w2;
        v2 = w2 ^ w1;
        v1 = w1 ^ w0;
        v0 = w0 ^ t_word;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        key_d   = key_q;
        round_d = round_q;
        valid_d = valid_q;
        busy_d  = busy_q;
        unique case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    key_d   = bus.key_in;
                    cnt_d   = 4'd1;
                    busy_d  = 1'b1;
                    state_d = ST_EXPAND;
                end
            end
            ST_EXPAND: begin
                key_d = {f0, f1, f2, f3};
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == ROUNDS) begin
                    cnt_d   = '0;
                    round_d = ROUNDS;
                    valid_d = 1'b1;
                    state_d = ST_SERVE;
                end
            end
            ST_SERVE: begin
                if (bus.next) begin
                    if (round_q != 4'd0) begin
                        key_d   = {v0, v1, v2, v3};
                        round_d = round_q - 4'd1;
                    end else begin
                        // key_q already holds the cipher key; it stays visible in IDLE.
                        valid_d = 1'b0;
                        busy_d  = 1'b0;
                        round_d = '0;
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            key_q   <= '0;
            round_q <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            key_q   <= key_d;
            round_q <= round_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
        end
    end

    assign bus.key_out   = key_q;
    assign bus.key_round = round_q;
    assign bus.key_valid = valid_q;
    assign bus.busy      = busy_q;
    assign dbg_state     = state_q;

endmodule

// File: tb/tb_aes_inv_key_schedule.sv
// Bench for aes_inv_key_schedule: reference schedule from GF(2^8) arithmetic and
// the forward FIPS-197 word recurrence, served keys checked in order 10..0.
module tb_aes_inv_key_schedule;
    import aes_pkg::*;

    logic   clk = 1'b0;
    logic   reset_n;
    state_t dbg_state;

    aes_inv_key_schedule_if ks_if ();

    aes_inv_key_schedule dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .bus       (ks_if),
        .dbg_state (dbg_state)
    );

    always #5 clk = ~clk;

    int           n_tests = 0;
    int           n_fail  = 0;
    logic [7:0]   sb_model [256];
    logic [127:0] rk_model [11];
    logic [127:0] exp_q [$];

    // ---------------- reference model ----------------
    function automatic logic [7:0] gf_mul(input logic [7:0] a_in, input logic [7:0] b_in);
        logic [7:0] a, b, p;
        a = a_in;
        b = b_in;
        p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            a = a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
            b = b >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
        return (x << n) | (x >> (8 - n));
    endfunction

    task automatic build_sbox();
        logic [7:0] inv;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h01;
            if (x == 0) inv = 8'h00;
            else for (int k = 0; k < 253; k++) inv = gf_mul(inv, 8'(x));
            if (x != 0) inv = gf_mul(inv, 8'(x));
            sb_model[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    task automatic expand_key(input logic [127:0] key);
        logic [31:0] w [44];
        logic [31:0] tmp;
        logic [7:0]  rc;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            tmp = w[i-1];
            if (i % 4 == 0) begin
                tmp = {tmp[23:0], tmp[31:24]};
                tmp = {sb_model[tmp[31:24]], sb_model[tmp[23:16]], sb_model[tmp[15:8]], sb_model[tmp[7:0]]};
                tmp = tmp ^ {rc, 24'h000000};
                rc  = gf_mul(rc, 8'h02);
            end
            w[i] = w[i-4] ^ tmp;
        end
        for (int r = 0; r <= 10; r++) rk_model[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    task automatic load_exp(input int from_round);
        exp_q.delete();
        for (int r = from_round; r >= 0; r--) exp_q.push_back(rk_model[r]);
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [127:0] key);
        ks_if.key_in = key;
        ks_if.start  = 1'b1;
        tick();
        ks_if.start  = 1'b0;
        ks_if.key_in = {$urandom(), $urandom(), $urandom(), $urandom()};
    endtask

    task automatic wait_valid(input int exp_cycles, input string tag);
        int c;
        c = 0;
        while (ks_if.key_valid !== 1'b1 && c < 40) begin
            tick();
            c++;
        end
        n_tests++;
        if (c !== exp_cycles) begin
            n_fail++;
            $display("FAIL %s latency: got %0d cycles, want %0d", tag, c, exp_cycles);
        end
    endtask

    // Serves exp_q from first_round down to 0 with random gaps, then checks the return to idle.
    task automatic serve_and_check(input logic [127:0] key, input int max_gap, input int first_round);
        logic [127:0] want;
        int           g;
        for (int r = first_round; r >= 0; r--) begin
            want = exp_q.pop_front();
            n_tests++;
            if (ks_if.key_valid !== 1'b1 || ks_if.key_round !== 4'(r) || ks_if.key_out !== want) begin
                n_fail++;
                $display("FAIL serve r%0d: got v=%b r=%0d k=%h, want v=1 r=%0d k=%h",
                         r, ks_if.key_valid, ks_if.key_round, ks_if.key_out, r, want);
            end
            g = $urandom_range(0, max_gap);
            repeat (g) tick();
            if (g > 0) begin
                n_tests++;
                if (ks_if.key_round !== 4'(r) || ks_if.key_out !== want) begin
                    n_fail++;
                    $display("FAIL hold r%0d: got r=%0d k=%h, want r=%0d k=%h",
                             r, ks_if.key_round, ks_if.key_out, r, want);
                end
            end
            ks_if.next = 1'b1;
            tick();
            ks_if.next = 1'b0;
        end
        n_tests++;
        if (ks_if.busy !== 1'b0 || ks_if.key_valid !== 1'b0 || ks_if.key_round !== 4'd0 ||
            ks_if.key_out !== key) begin
            n_fail++;
            $display("FAIL end_state: got busy=%b v=%b r=%0d k=%h, want 0 0 0 k=%h",
                     ks_if.busy, ks_if.key_valid, ks_if.key_round, ks_if.key_out, key);
        end
    endtask

    task automatic run_key(input logic [127:0] key, input int max_gap);
        expand_key(key);
        load_exp(10);
        do_start(key);
        n_tests++;
        if (ks_if.busy !== 1'b1 || ks_if.key_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL start_accept: got busy=%b v=%b, want 1 0", ks_if.busy, ks_if.key_valid);
        end
        wait_valid(10, "run_key");
        serve_and_check(key, max_gap, 10);
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        reset_n      = 1'b0;
        ks_if.start  = 1'b0;
        ks_if.next   = 1'b0;
        ks_if.key_in = '0;
        repeat (2) @(posedge clk);
        #1;
        n_tests++;
        if (ks_if.key_out !== 128'h0 || ks_if.key_round !== 4'd0) begin
            n_fail++;
            $display("FAIL reset_key: got k=%h r=%0d, want 0 0", ks_if.key_out, ks_if.key_round);
        end
        n_tests++;
        if (ks_if.key_valid !== 1'b0 || ks_if.busy !== 1'b0 || dbg_state !== ST_IDLE) begin
            n_fail++;
            $display("FAIL reset_flags: got v=%b busy=%b st=%0d, want 0 0 0",
                     ks_if.key_valid, ks_if.busy, dbg_state);
        end
        reset_n = 1'b1;
        tick();
    endtask

    task automatic test_fips_single();
        logic [127:0] key;
        key = 128'h2b7e151628aed2a6abf7158809cf4f3c;
        expand_key(key);
        do_start(key);
        wait_valid(10, "fips");
        n_tests++;
        if (ks_if.key_round !== 4'd10 || ks_if.key_out !== 128'hd014f9a8c9ee2589e13f0cc8b6630ca6) begin
            n_fail++;
            $display("FAIL fips_r10: got r=%0d k=%h, want 10 d014f9a8c9ee2589e13f0cc8b6630ca6",
                     ks_if.key_round, ks_if.key_out);
        end
        repeat (3) tick();
        n_tests++;
        if (ks_if.key_round !== 4'd10 || ks_if.key_out !== 128'hd014f9a8c9ee2589e13f0cc8b6630ca6) begin
            n_fail++;
            $display("FAIL fips_hold: got r=%0d k=%h, want 10 d014f9a8c9ee2589e13f0cc8b6630ca6",
                     ks_if.key_round, ks_if.key_out);
        end
        ks_if.next = 1'b1;
        tick();
        ks_if.next = 1'b0;
        n_tests++;
        if (ks_if.key_round !== 4'd9 || ks_if.key_out !== 128'hac7766f319fadc2128d12941575c006e) begin
            n_fail++;
            $display("FAIL fips_r9: got r=%0d k=%h, want 9 ac7766f319fadc2128d12941575c006e",
                     ks_if.key_round, ks_if.key_out);
        end
        load_exp(9);
        serve_and_check(key, 0, 9);
    endtask

    task automatic test_held_next();
        logic [127:0] key;
        key = 128'h2b7e151628aed2a6abf7158809cf4f3c;
        expand_key(key);
        do_start(key);
        wait_valid(10, "held");
        ks_if.next = 1'b1;
        for (int r = 10; r >= 0; r--) begin
            n_tests++;
            if (ks_if.key_valid !== 1'b1 || ks_if.key_round !== 4'(r) || ks_if.key_out !== rk_model[r]) begin
                n_fail++;
                $display("FAIL held r%0d: got v=%b r=%0d k=%h, want 1 %0d %h",
                         r, ks_if.key_valid, ks_if.key_round, ks_if.key_out, r, rk_model[r]);
            end
            tick();
        end
        ks_if.next = 1'b0;
        n_tests++;
        if (ks_if.busy !== 1'b0 || ks_if.key_valid !== 1'b0 || dbg_state !== ST_IDLE) begin
            n_fail++;
            $display("FAIL held_idle: got busy=%b v=%b st=%0d, want 0 0 0",
                     ks_if.busy, ks_if.key_valid, dbg_state);
        end
    endtask

    task automatic test_zero_key();
        expand_key('0);
        do_start('0);
        wait_valid(10, "zero");
        n_tests++;
        if (ks_if.key_out !== 128'hb4ef5bcb3e92e21123e951cf6f8f188e) begin
            n_fail++;
            $display("FAIL zero_r10: got %h, want b4ef5bcb3e92e21123e951cf6f8f188e", ks_if.key_out);
        end
        load_exp(10);
        serve_and_check('0, 1, 10);
    endtask

    task automatic test_start_during_expand();
        logic [127:0] key_a;
        key_a = {$urandom(), $urandom(), $urandom(), $urandom()};
        expand_key(key_a);
        load_exp(10);
        do_start(key_a);
        repeat (3) tick();
        n_tests++;
        if (ks_if.busy !== 1'b1 || ks_if.key_valid !== 1'b0 || dbg_state !== ST_EXPAND) begin
            n_fail++;
            $display("FAIL mid_expand: got busy=%b v=%b st=%0d, want 1 0 1",
                     ks_if.busy, ks_if.key_valid, dbg_state);
        end
        ks_if.start  = 1'b1;
        ks_if.key_in = ~key_a;
        ks_if.next   = 1'b1;
        tick();
        ks_if.start = 1'b0;
        repeat (2) tick();
        ks_if.next = 1'b0;
        wait_valid(4, "restart_ignored");
        n_tests++;
        if (ks_if.key_round !== 4'd10) begin
            n_fail++;
            $display("FAIL expand_next_round: got %0d, want 10", ks_if.key_round);
        end
        serve_and_check(key_a, 1, 10);
    endtask

    task automatic test_reset_mid_serve();
        logic [127:0] key;
        key = {$urandom(), $urandom(), $urandom(), $urandom()};
        expand_key(key);
        do_start(key);
        wait_valid(10, "pre_reset");
        repeat (5) begin
            ks_if.next = 1'b1;
            tick();
            ks_if.next = 1'b0;
        end
        n_tests++;
        if (ks_if.key_round !== 4'd5 || ks_if.key_out !== rk_model[5]) begin
            n_fail++;
            $display("FAIL pre_reset_r5: got r=%0d k=%h, want 5 %h", ks_if.key_round, ks_if.key_out, rk_model[5]);
        end
        reset_n = 1'b0;
        #1;
        n_tests++;
        if (ks_if.key_out !== 128'h0 || ks_if.key_round !== 4'd0 || ks_if.key_valid !== 1'b0 ||
            ks_if.busy !== 1'b0 || dbg_state !== ST_IDLE) begin
            n_fail++;
            $display("FAIL async_reset: got k=%h r=%0d v=%b busy=%b st=%0d, want all 0",
                     ks_if.key_out, ks_if.key_round, ks_if.key_valid, ks_if.busy, dbg_state);
        end
        #2;
        reset_n = 1'b1;
        tick();
        run_key(key, 0);
    endtask

    task automatic test_back_to_back();
        logic [127:0] key_a, key_b;
        key_a = {$urandom(), $urandom(), $urandom(), $urandom()};
        key_b = {$urandom(), $urandom(), $urandom(), $urandom()};
        expand_key(key_a);
        do_start(key_a);
        wait_valid(10, "b2b_a");
        ks_if.next = 1'b1;
        repeat (10) tick();
        n_tests++;
        if (ks_if.key_round !== 4'd0 || ks_if.key_out !== key_a) begin
            n_fail++;
            $display("FAIL b2b_r0: got r=%0d k=%h, want 0 %h", ks_if.key_round, ks_if.key_out, key_a);
        end
        ks_if.start  = 1'b1;
        ks_if.key_in = key_b;
        tick();
        ks_if.start = 1'b0;
        ks_if.next  = 1'b0;
        n_tests++;
        if (ks_if.busy !== 1'b0 || ks_if.key_valid !== 1'b0 || ks_if.key_out !== key_a) begin
            n_fail++;
            $display("FAIL b2b_start_ignored: got busy=%b v=%b k=%h, want 0 0 %h",
                     ks_if.busy, ks_if.key_valid, ks_if.key_out, key_a);
        end
        run_key(key_b, 0);
    endtask

    task automatic test_random();
        logic [127:0] key;
        for (int n = 0; n < 1000; n++) begin
            key = {$urandom(), $urandom(), $urandom(), $urandom()};
            run_key(key, 2);
        end
    endtask

    initial begin
        build_sbox();
        test_reset();
        test_fips_single();
        test_held_next();
        test_zero_key();
        test_start_during_expand();
        test_reset_mid_serve();
        test_back_to_back();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
